// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one pipelined CORDIC rotator among NREQ requesters. Each enabled
//   cycle one pending request is picked round-robin and its operands are
//   registered into the rotator. A tag pipeline follows the operation through
//   the rotator, so each result goes back to the requester that issued it. The
//   rotator's aux bit is checked against the tag pipeline's valid bit, and any
//   disagreement sets a sticky error flag.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset (priority over i_ce)
//   i_ce                global clock enable, shared with the rotator
//   i_req               per-requester request valid
//   i_xval/i_yval       packed x/y operands, requester k at [k*IW +: IW]
//   i_phase             packed phases, requester k at [k*PW +: PW]
//   o_gnt               one-hot combinational grant
//   o_cx/o_cy/o_cph     registered operands to the rotator
//   o_caux              registered valid bit to the rotator aux input
//   i_cx/i_cy/i_caux    rotator outputs
//   o_rvalid            one-hot registered result strobe, held during stalls
//   o_rx/o_ry           result x/y, valid with o_rvalid
//   o_busy              an operation is in flight
//   o_err               sticky aux/tag disagreement
//
// Handshake: a requester raises i_req[k] with its operands and keeps both
// stable. In the cycle where o_gnt[k] is high (which needs i_ce=1), the
// operands are captured. From the next cycle the requester may drop or change
// them. The return side has no ready: o_rvalid[k] marks exactly one result per
// issued operation, in grant order.

module cordic_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 13,
    parameter int OW   = 13,
    parameter int PW   = 20,
    parameter int CLAT = 18,
    parameter int TW   = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*IW-1:0]   i_xval,
    input  logic [NREQ*IW-1:0]   i_yval,
    input  logic [NREQ*PW-1:0]   i_phase,
    output logic [NREQ-1:0]      o_gnt,
    output logic [IW-1:0]        o_cx,
    output logic [IW-1:0]        o_cy,
    output logic [PW-1:0]        o_cph,
    output logic                 o_caux,
    input  logic [OW-1:0]        i_cx,
    input  logic [OW-1:0]        i_cy,
    input  logic                 i_caux,
    output logic [NREQ-1:0]      o_rvalid,
    output logic [OW-1:0]        o_rx,
    output logic [OW-1:0]        o_ry,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int CW = $clog2(CLAT + 3);

    logic [TW-1:0] rr_ptr;
    logic          gnt_any;
    logic [TW-1:0] gnt_id;
    logic [TW:0]   cand_sum;
    logic [TW-1:0] cand;

    // Tag pipeline: entry 0 is written with the grant of the current cycle.
    // Entry CLAT lines up with the rotator output that belongs to it.
    logic          tag_v  [0:CLAT];
    logic [TW-1:0] tag_id [0:CLAT];

    logic          ret;
    logic [CW-1:0] inflight;

    // Round-robin search that starts at rr_ptr and wraps modulo NREQ.
    // NREQ need not be a power of two, so the wrap is an explicit subtract.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        cand_sum = '0;
        cand     = '0;
        if (i_ce && !i_reset) begin
            for (int i = 0; i < NREQ; i++) begin
                cand_sum = {1'b0, rr_ptr} + (TW+1)'(i);
                if (cand_sum >= (TW+1)'(NREQ))
                    cand_sum = cand_sum - (TW+1)'(NREQ);
                cand = cand_sum[TW-1:0];
                if (!gnt_any && i_req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    assign o_gnt  = gnt_any ? (NREQ'(1) << gnt_id) : '0;
    assign ret    = i_ce && tag_v[CLAT];
    assign o_busy = (inflight != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k <= CLAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else if (i_ce) begin
            tag_v[0]  <= gnt_any;
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= CLAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr   <= '0;
            o_cx     <= '0;
            o_cy     <= '0;
            o_cph    <= '0;
            o_caux   <= 1'b0;
            o_rvalid <= '0;
            o_rx     <= '0;
            o_ry     <= '0;
            o_err    <= 1'b0;
            inflight <= '0;
        end else if (i_ce) begin
            // Issue: operands hold when nothing is granted; only aux drops.
            o_caux <= gnt_any;
            if (gnt_any) begin
                o_cx   <= i_xval[int'(gnt_id)*IW +: IW];
                o_cy   <= i_yval[int'(gnt_id)*IW +: IW];
                o_cph  <= i_phase[int'(gnt_id)*PW +: PW];
                rr_ptr <= (gnt_id == TW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            end

            // Return: the tail tag names the requester that owns i_cx/i_cy.
            if (ret) begin
                o_rvalid <= NREQ'(1) << tag_id[CLAT];
                o_rx     <= i_cx;
                o_ry     <= i_cy;
            end else begin
                o_rvalid <= '0;
            end

            if (i_caux != tag_v[CLAT])
                o_err <= 1'b1;

            case ({gnt_any, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
